apb3_master_ctrl: RTL and testbench

//  APB3 initiator: turns single-beat commands from a valid/ready port into APB3 read/write

---
 rtl/apb3_master_ctrl.sv | 110 +++++++++++
 tb/tb_apb3_master_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_master_ctrl.sv
// APB3 initiator: single-beat valid/ready commands in, APB3 SETUP/ACCESS transfers out,
// one-cycle response pulse back. Optional wait-state watchdog under `APB_MASTER_TIMEOUT_EN.
module apb3_master_ctrl #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
  state_t state;

  // Handshake: a command is taken on a rising edge where cmd_valid & cmd_ready;
  // the requester holds cmd_* stable until then. rsp_valid has no backpressure.
  assign cmd_ready = (state == IDLE) && !PRESET;
  assign dbg_state = state;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] wait_cnt;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
          end else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            // This edge completes the last permitted wait cycle: abort the transfer.
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_master_ctrl.sv
// Bench for apb3_master_ctrl: directed cases plus random commands against a planned APB
// slave; expected responses and latencies go through queues checked by a monitor.
`timescale 1ns/1ps
module tb_apb3_master_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif
  localparam int DUT_TMO = (TMO == 0) ? 255 : TMO;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL, PENABLE, PWRITE;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic              PREADY, PSLVERR;
  logic [1:0]        dbg_state;

  apb3_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(DUT_TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int              waits;
    logic [DATA_W-1:0] rdata;
    logic            err;
    logic            wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } plan_t;

  plan_t                plan_q[$];
  logic [DATA_W+1:0]    exp_q[$];   // {timeout, err, rdata}
  int                   lat_q[$];
  int                   acc_q[$];
  int                   checks = 0;
  int                   errors = 0;
  int                   wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave model ----------------
  always @(negedge PCLK) begin
    plan_t p;
    if (PRESET) begin
      plan_q.delete();
      wcnt    = 0;
      PREADY  = 1'($urandom);
      PRDATA  = 8'($urandom);
      PSLVERR = 1'($urandom);
    end else if (PSEL && PENABLE) begin
      if (plan_q.size() == 0) begin
        chk("unplanned_access", 32'd1, 32'd0);
        PREADY = 1'b1;
      end else begin
        p = plan_q[0];
        chk("apb_fields", {PWRITE, PADDR, PWDATA}, {p.wr, p.addr, p.wdata});
        if (wcnt == p.waits) begin
          PREADY  = 1'b1;
          PRDATA  = p.rdata;
          PSLVERR = p.err;
          void'(plan_q.pop_front());
          wcnt = 0;
        end else begin
          PREADY  = 1'b0;
          PRDATA  = 8'($urandom);
          PSLVERR = 1'($urandom);
          if (TMO > 0 && wcnt == TMO - 1) begin
            void'(plan_q.pop_front());
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
    end else begin
      PREADY  = 1'($urandom);
      PRDATA  = 8'($urandom);
      PSLVERR = 1'($urandom);
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge PCLK) begin
    logic [DATA_W+1:0] e;
    int l, a;
    if (PENABLE && !PSEL) chk("penable_without_psel", 32'd1, 32'd0);
    if (rsp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        a = acc_q.pop_front();
        chk("rsp_fields", {rsp_timeout, rsp_err, rsp_rdata}, e);
        chk("rsp_latency", cyc - a, l);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input int waits, input logic [DATA_W-1:0] rd, input logic er,
                      input bit expect_rsp, output int acc);
    plan_t p;
    int budget;
    p.waits = waits; p.rdata = rd; p.err = er; p.wr = wr; p.addr = a; p.wdata = d;
    plan_q.push_back(p);
    if (expect_rsp) begin
      if (TMO > 0 && waits >= TMO) begin
        exp_q.push_back({1'b1, 1'b1, {DATA_W{1'b0}}});
        lat_q.push_back(2 + TMO);
      end else begin
        exp_q.push_back({1'b0, er, wr ? {DATA_W{1'b0}} : rd});
        lat_q.push_back(3 + waits);
      end
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    budget = 0;
    while (!cmd_ready && budget < 3000) begin
      @(negedge PCLK);
      budget++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge PCLK);
    acc = cyc;
    if (expect_rsp) acc_q.push_back(cyc);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 5'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(negedge PCLK);
      b++;
    end
    chk("drain", exp_q.size(), 32'd0);
    @(negedge PCLK);
  endtask

  task automatic reset_in_access();
    int b = 0;
    while (!(PSEL && PENABLE) && b < 50) begin
      @(negedge PCLK);
      b++;
    end
    chk("reached_access", {PSEL, PENABLE}, 2'b11);
    #1 PRESET = 1'b1;
    @(negedge PCLK);
    chk("rst_mid_psel", PSEL, 1'b0);
    chk("rst_mid_penable", PENABLE, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    #1 PRESET = 1'b0;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge PCLK);
    chk("post_rst_no_rsp", rsp_valid, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a1, a2;
    logic wr;
    int w;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 5'd0);
    chk("rst_pwdata", PWDATA, 8'd0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 11'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    #1 PRESET = 1'b0;
    #1 chk("cmd_ready_after_rst", cmd_ready, 1'b1);
    @(negedge PCLK);

    // write, zero wait states
    send(1'b1, 5'h08, 8'h1A, 0, 8'hEE, 1'b0, 1'b1, a1);
    chk("t1_setup", {PSEL, PENABLE}, 2'b10);
    @(negedge PCLK);
    chk("t1_access", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 5'h08, 8'h1A});
    wait_idle();

    // read with two wait states
    send(1'b0, 5'h10, 8'h00, 2, 8'h03, 1'b0, 1'b1, a1);
    chk("t2_setup", {PSEL, PENABLE, PADDR}, {2'b10, 5'h10});
    repeat (3) begin
      @(negedge PCLK);
      chk("t2_access_hold", {PSEL, PENABLE, PADDR}, {2'b11, 5'h10});
    end
    wait_idle();

    // read with slave error
    send(1'b0, 5'h04, 8'h00, 0, 8'h5C, 1'b1, 1'b1, a1);
    wait_idle();

    // back-to-back write then read
    send(1'b1, 5'h0C, 8'h01, 0, 8'h00, 1'b0, 1'b1, a1);
    send(1'b0, 5'h0C, 8'h00, 0, 8'h77, 1'b0, 1'b1, a2);
    chk("b2b_accept_gap", a2 - a1, 32'd3);
    chk("b2b_psel_again", PSEL, 1'b1);
    wait_idle();

`ifdef APB_MASTER_TIMEOUT_EN
    send(1'b0, 5'h01, 8'h00, TMO - 1, 8'hA5, 1'b0, 1'b1, a1);
    wait_idle();
    send(1'b0, 5'h02, 8'h00, 1000, 8'h3C, 1'b0, 1'b1, a1);
    wait_idle();
    send(1'b1, 5'h03, 8'h99, 1, 8'h00, 1'b0, 1'b1, a1);
    wait_idle();
    send(1'b0, 5'h05, 8'h00, 3, 8'h11, 1'b0, 1'b0, a1);
    reset_in_access();
`else
    send(1'b0, 5'h02, 8'h00, 2000, 8'h3C, 1'b0, 1'b0, a1);
    repeat (1000) @(negedge PCLK);
    chk("no_timeout_still_waiting", {PSEL, PENABLE}, 2'b11);
    reset_in_access();
`endif

    repeat (60) begin
      wr = 1'($urandom);
      w  = (TMO > 0) ? $urandom_range(0, TMO + 1) : $urandom_range(0, 3);
      send(wr, 5'($urandom), 8'($urandom), w, 8'($urandom), 1'($urandom), 1'b1, a1);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
